// File: rtl/updown_counter_n_if.sv
// Control/status bundle for updown_counter_n: the master drives the count
// controls, the slave (the counter) returns count, terminal-count and overflow.
interface updown_counter_n_if #(
  parameter int WIDTH = 8
);
  logic             en_i;
  logic             load_i;
  logic [WIDTH-1:0] data_i;
  logic             dir_i;
  logic             sat_i;
  logic             clr_ovf_i;
  logic [WIDTH-1:0] cnt_o;
  logic             tc_o;
  logic             ovf_o;

  modport master (
    output en_i, load_i, data_i, dir_i, sat_i, clr_ovf_i,
    input  cnt_o, tc_o, ovf_o
  );

  modport slave (
    input  en_i, load_i, data_i, dir_i, sat_i, clr_ovf_i,
    output cnt_o, tc_o, ovf_o
  );
endinterface

// File: rtl/updown_counter_n.sv
// N-bit up/down modulo counter with enable prescaler, wrap/saturate bounds,
// one-cycle terminal-count pulse and sticky overflow flag.
module updown_counter_n #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] MAX_VAL   = '1,
  parameter int unsigned      PRESCALE  = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  updown_counter_n_if.slave        bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    p_q, p_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             tick;
  logic             boundary;

  assign tick = bus.en_i && (p_q == P_LAST);

  always_comb begin
    cnt_d    = cnt_q;
    p_d      = p_q;
    tc_d     = 1'b0;
    ovf_d    = ovf_q;
    boundary = 1'b0;

    if (bus.clr_ovf_i) begin
      ovf_d = 1'b0;
    end

    if (bus.load_i) begin
      // Out-of-range loads clamp so the count never leaves 0..MAX_VAL.
      cnt_d = (bus.data_i > MAX_VAL) ? MAX_VAL : bus.data_i;
      p_d   = '0;
    end else begin
      if (bus.en_i) begin
        p_d = (p_q == P_LAST) ? '0 : p_q + PW'(1);
      end
      if (tick) begin
        if (bus.dir_i) begin
          if (cnt_q >= MAX_VAL) begin
            boundary = 1'b1;
            cnt_d    = bus.sat_i ? MAX_VAL : '0;
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end else begin
          if (cnt_q == '0) begin
            boundary = 1'b1;
            cnt_d    = bus.sat_i ? '0 : MAX_VAL;
          end else begin
            cnt_d = cnt_q - WIDTH'(1);
          end
        end
      end
    end

    // A boundary event outranks a simultaneous overflow clear.
    if (boundary) begin
      tc_d  = 1'b1;
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= RESET_VAL;
      p_q   <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      p_q   <= p_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.cnt_o = cnt_q;
  assign bus.tc_o  = tc_q;
  assign bus.ovf_o = ovf_q;

endmodule

// File: tb/tb_updown_counter_n.sv
// Directed bench for updown_counter_n: three parameterisations, expectations
// queued as each step is driven and checked just after the following edge.
module tb_updown_counter_n;

  logic clk;
  logic rst;

  updown_counter_n_if #(.WIDTH(8)) if_a ();
  updown_counter_n_if #(.WIDTH(4)) if_b ();
  updown_counter_n_if #(.WIDTH(8)) if_c ();

  updown_counter_n #(.WIDTH(8)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if_a)
  );

  updown_counter_n #(.WIDTH(4), .MAX_VAL(4'd9), .RESET_VAL(4'd3)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if_b)
  );

  updown_counter_n #(.WIDTH(8), .PRESCALE(4)) dut_c (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    int         dut;
    logic [7:0] cnt;
    logic       tc;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [7:0] obs_cnt(int d);
    case (d)
      0:       return if_a.cnt_o;
      1:       return {4'b0000, if_b.cnt_o};
      default: return if_c.cnt_o;
    endcase
  endfunction

  function automatic logic obs_tc(int d);
    case (d)
      0:       return if_a.tc_o;
      1:       return if_b.tc_o;
      default: return if_c.tc_o;
    endcase
  endfunction

  function automatic logic obs_ovf(int d);
    case (d)
      0:       return if_a.ovf_o;
      1:       return if_b.ovf_o;
      default: return if_c.ovf_o;
    endcase
  endfunction

  task automatic expect_q(int d, string tag, logic [7:0] c, logic t, logic o);
    exp_t e;
    e.tag = tag;
    e.dut = d;
    e.cnt = c;
    e.tc  = t;
    e.ovf = o;
    sb.push_back(e);
  endtask

  task automatic compare_all();
    exp_t       e;
    logic [7:0] oc;
    logic       ot;
    logic       oo;
    while (sb.size() > 0) begin
      e  = sb.pop_front();
      oc = obs_cnt(e.dut);
      ot = obs_tc(e.dut);
      oo = obs_ovf(e.dut);
      checks++;
      assert (oc === e.cnt) else begin
        errors++;
        $error("FAIL %s cnt_o: got %0d expected %0d", e.tag, oc, e.cnt);
      end
      checks++;
      assert (ot === e.tc) else begin
        errors++;
        $error("FAIL %s tc_o: got %b expected %b", e.tag, ot, e.tc);
      end
      checks++;
      assert (oo === e.ovf) else begin
        errors++;
        $error("FAIL %s ovf_o: got %b expected %b", e.tag, oo, e.ovf);
      end
      $display("step %s dut%0d cnt=%0d tc=%b ovf=%b", e.tag, e.dut, oc, ot, oo);
    end
  endtask

  task automatic edge_check();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drv(int d, logic en, logic ld, logic [7:0] data,
                     logic dir, logic sat, logic clr);
    case (d)
      0: begin
        if_a.en_i = en; if_a.load_i = ld; if_a.data_i = data;
        if_a.dir_i = dir; if_a.sat_i = sat; if_a.clr_ovf_i = clr;
      end
      1: begin
        if_b.en_i = en; if_b.load_i = ld; if_b.data_i = data[3:0];
        if_b.dir_i = dir; if_b.sat_i = sat; if_b.clr_ovf_i = clr;
      end
      default: begin
        if_c.en_i = en; if_c.load_i = ld; if_c.data_i = data;
        if_c.dir_i = dir; if_c.sat_i = sat; if_c.clr_ovf_i = clr;
      end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0);
    drv(2, 0, 0, 0, 0, 0, 0);
    #2;
    expect_q(0, "rst_a", 0, 0, 0);
    expect_q(1, "rst_b", 3, 0, 0);
    expect_q(2, "rst_c", 0, 0, 0);
    compare_all();
    #2;
    rst = 1'b0;

    // Up, wrap through 255 -> 0
    drv(0, 1, 1, 254, 1, 0, 0);
    expect_q(0, "t1_load", 254, 0, 0); edge_check();
    drv(0, 1, 0, 0, 1, 0, 0);
    expect_q(0, "t1_255", 255, 0, 0); edge_check();
    expect_q(0, "t1_wrap", 0, 1, 1); edge_check();
    expect_q(0, "t1_one", 1, 0, 1); edge_check();

    // Overflow clear versus simultaneous wrap
    drv(0, 0, 1, 255, 1, 0, 0);
    expect_q(0, "t6_load", 255, 0, 1); edge_check();
    drv(0, 0, 0, 0, 1, 0, 1);
    expect_q(0, "t6_clr", 255, 0, 0); edge_check();
    drv(0, 1, 0, 0, 1, 0, 1);
    expect_q(0, "t6_wrap_clr", 0, 1, 1); edge_check();
    drv(0, 0, 0, 0, 1, 0, 1);
    expect_q(0, "t6_clr2", 0, 0, 0); edge_check();

    // Down, saturate at 0
    drv(0, 0, 1, 1, 0, 1, 0);
    expect_q(0, "t2_load", 1, 0, 0); edge_check();
    drv(0, 1, 0, 0, 0, 1, 0);
    expect_q(0, "t2_dec", 0, 0, 0); edge_check();
    repeat (3) begin
      expect_q(0, "t2_sat", 0, 1, 1); edge_check();
    end
    drv(0, 0, 0, 0, 0, 1, 0);
    expect_q(0, "t2_idle", 0, 0, 1); edge_check();
    drv(0, 0, 0, 0, 0, 1, 1);
    expect_q(0, "t2_clr", 0, 0, 0); edge_check();
    drv(0, 0, 0, 0, 0, 0, 0);

    // Modulo 10 on the 4-bit instance
    drv(1, 0, 1, 8, 1, 0, 0);
    expect_q(1, "t3_load8", 8, 0, 0); edge_check();
    drv(1, 1, 0, 0, 1, 0, 0);
    expect_q(1, "t3_nine", 9, 0, 0); edge_check();
    expect_q(1, "t3_wrap_up", 0, 1, 1); edge_check();
    drv(1, 1, 0, 0, 0, 0, 0);
    expect_q(1, "t3_wrap_dn", 9, 1, 1); edge_check();
    drv(1, 1, 0, 0, 1, 1, 0);
    expect_q(1, "t3_sat_max", 9, 1, 1); edge_check();
    drv(1, 0, 1, 12, 1, 0, 0);
    expect_q(1, "t3_clamp12", 9, 0, 1); edge_check();
    drv(1, 0, 1, 7, 1, 0, 0);
    expect_q(1, "t3_load7", 7, 0, 1); edge_check();
    drv(1, 0, 1, 15, 1, 0, 0);
    expect_q(1, "t3_clamp15", 9, 0, 1); edge_check();
    drv(1, 0, 0, 0, 0, 0, 0);

    // Prescale by 4
    drv(2, 1, 1, 10, 1, 0, 0);
    expect_q(2, "t4_load", 10, 0, 0); edge_check();
    drv(2, 1, 0, 0, 1, 0, 0);
    repeat (3) begin
      expect_q(2, "t4_wait", 10, 0, 0); edge_check();
    end
    expect_q(2, "t4_step11", 11, 0, 0); edge_check();
    repeat (3) begin
      expect_q(2, "t4_wait", 11, 0, 0); edge_check();
    end
    expect_q(2, "t4_step12", 12, 0, 0); edge_check();
    expect_q(2, "t4_p1", 12, 0, 0); edge_check();
    drv(2, 0, 0, 0, 1, 0, 0);
    repeat (2) begin
      expect_q(2, "t4_pause", 12, 0, 0); edge_check();
    end
    drv(2, 1, 0, 0, 1, 0, 0);
    repeat (2) begin
      expect_q(2, "t4_resume", 12, 0, 0); edge_check();
    end
    expect_q(2, "t4_step13", 13, 0, 0); edge_check();
    repeat (3) begin
      expect_q(2, "t4_wait", 13, 0, 0); edge_check();
    end
    drv(2, 1, 1, 50, 1, 0, 0);
    expect_q(2, "t4_load_on_tick", 50, 0, 0); edge_check();
    drv(2, 1, 0, 0, 1, 0, 0);
    repeat (3) begin
      expect_q(2, "t4_wait", 50, 0, 0); edge_check();
    end
    expect_q(2, "t4_step51", 51, 0, 0); edge_check();
    drv(2, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset mid-count
    drv(0, 0, 1, 254, 1, 0, 0);
    expect_q(0, "t5_load", 254, 0, 0); edge_check();
    drv(0, 1, 0, 0, 1, 0, 0);
    expect_q(0, "t5_255", 255, 0, 0); edge_check();
    expect_q(0, "t5_wrap", 0, 1, 1); edge_check();
    expect_q(0, "t5_1", 1, 0, 1); edge_check();
    expect_q(0, "t5_2", 2, 0, 1); edge_check();
    expect_q(0, "t5_3", 3, 0, 1); edge_check();
    expect_q(0, "t5_4", 4, 0, 1); edge_check();
    expect_q(0, "t5_5", 5, 0, 1); edge_check();
    #2;
    rst = 1'b1;
    #1;
    expect_q(0, "t5_async_a", 0, 0, 0);
    expect_q(1, "t5_async_b", 3, 0, 0);
    expect_q(2, "t5_async_c", 50 - 50, 0, 0);
    compare_all();
    #2;
    rst = 1'b0;
    expect_q(0, "t5_resume1", 1, 0, 0); edge_check();
    expect_q(0, "t5_resume2", 2, 0, 0); edge_check();
    drv(0, 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
